// File: rtl/toy_fetch_buffer_mw.sv
// Multi-lane in-order fetch buffer: compacts sparse write lanes into a circular
// array and presents the oldest MUX_OUT entries to decode with prefix release.
module toy_fetch_buffer_mw #(
  parameter int DEPTH     = 32,
  parameter int MUX_IN    = 2,
  parameter int MUX_OUT   = 2,
  parameter int PLD_WIDTH = 128
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cancel_en,
  input  logic                                req_vld,
  output logic                                req_rdy,
  input  logic [MUX_IN-1:0]                   v_req_en,
  input  logic [MUX_IN-1:0][PLD_WIDTH-1:0]    v_req_pld,
  output logic [MUX_OUT-1:0]                  v_ack_vld,
  input  logic [MUX_OUT-1:0]                  v_ack_rdy,
  output logic [MUX_OUT-1:0][PLD_WIDTH-1:0]   v_ack_pld,
  output logic [$clog2(DEPTH):0]              occ_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  function automatic logic [PW-1:0] popcnt_in(input logic [MUX_IN-1:0] v);
    logic [PW-1:0] cnt;
    cnt = {PW{1'b0}};
    for (int i = 0; i < MUX_IN; i++) begin
      cnt = cnt + PW'(v[i]);
    end
    return cnt;
  endfunction

  logic [PLD_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [PW-1:0]        occ_cnt_r;

  logic                 wren_s;
  logic [PW-1:0]        wr_cnt_s;
  logic [PW-1:0]        wr_add_s;
  logic [PW-1:0]        rd_num_s;
  logic [PW-1:0]        free_s;
  logic [AW-1:0]        wr_idx_s [MUX_IN];

  // Credit is all-or-nothing against the registered count only.
  assign free_s   = PW'(DEPTH) - occ_cnt_r;
  assign req_rdy  = (free_s >= PW'(MUX_IN));
  assign wren_s   = req_vld & req_rdy;
  assign wr_cnt_s = popcnt_in(v_req_en);
  assign wr_add_s = wren_s ? wr_cnt_s : {PW{1'b0}};
  assign occ_cnt  = occ_cnt_r;

  // Compacted write slot per lane: base pointer plus enabled lanes below it.
  always_comb begin
    logic [PW-1:0] run_v;
    run_v = {PW{1'b0}};
    for (int i = 0; i < MUX_IN; i++) begin
      wr_idx_s[i] = wr_ptr_r[AW-1:0] + run_v[AW-1:0];
      run_v       = run_v + PW'(v_req_en[i]);
    end
  end

  // Release count: leading lanes with both valid and ready, stopping at the first hole.
  always_comb begin
    logic stop_v;
    rd_num_s = {PW{1'b0}};
    stop_v   = 1'b0;
    for (int i = 0; i < MUX_OUT; i++) begin
      if (!stop_v && v_ack_vld[i] && v_ack_rdy[i]) begin
        rd_num_s = rd_num_s + PW'(1);
      end else begin
        stop_v = 1'b1;
      end
    end
  end

  // Payload storage; contents survive cancel and reset.
  always_ff @(posedge clk) begin
    if (wren_s && !cancel_en) begin
      for (int i = 0; i < MUX_IN; i++) begin
        if (v_req_en[i]) begin
          mem_r[wr_idx_s[i]] <= v_req_pld[i];
        end
      end
    end
  end

  // Pointer and occupancy state; cancel outranks any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      occ_cnt_r <= {PW{1'b0}};
    end else if (cancel_en) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      occ_cnt_r <= {PW{1'b0}};
    end else begin
      wr_ptr_r  <= wr_ptr_r + wr_add_s;
      rd_ptr_r  <= rd_ptr_r + rd_num_s;
      occ_cnt_r <= occ_cnt_r + wr_add_s - rd_num_s;
    end
  end

  for (genvar g = 0; g < MUX_OUT; g++) begin : g_ack
    assign v_ack_vld[g] = (occ_cnt_r > PW'(g));
    assign v_ack_pld[g] = mem_r[rd_ptr_r[AW-1:0] + AW'(g)];
  end

endmodule

// File: tb/tb_toy_fetch_buffer_mw.sv
// Self-checking bench for toy_fetch_buffer_mw: vector table plus queue scoreboard.
module tb_toy_fetch_buffer_mw;

  localparam int DEPTH = 32;
  localparam int MI    = 2;
  localparam int MO    = 2;
  localparam int PLW   = 128;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cancel_en;
  logic                     req_vld;
  logic                     req_rdy;
  logic [MI-1:0]            v_req_en;
  logic [MI-1:0][PLW-1:0]   v_req_pld;
  logic [MO-1:0]            v_ack_vld;
  logic [MO-1:0]            v_ack_rdy;
  logic [MO-1:0][PLW-1:0]   v_ack_pld;
  logic [5:0]               occ_cnt;

  toy_fetch_buffer_mw #(.DEPTH(DEPTH), .MUX_IN(MI), .MUX_OUT(MO), .PLD_WIDTH(PLW)) dut (
    .clk(clk), .rst_n(rst_n), .cancel_en(cancel_en), .req_vld(req_vld), .req_rdy(req_rdy),
    .v_req_en(v_req_en), .v_req_pld(v_req_pld), .v_ack_vld(v_ack_vld), .v_ack_rdy(v_ack_rdy),
    .v_ack_pld(v_ack_pld), .occ_cnt(occ_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cxl;
    logic       vld;
    logic [1:0] en;
    logic [1:0] rdy;
    int         exp_occ;
    logic       exp_rdy;
  } vec_t;

  vec_t         vecs[12];
  logic [PLW-1:0] mq[$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare every output against the reference queue of outstanding entries.
  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("occ_cnt", PLW'(occ_cnt), PLW'(n));
    chk("req_rdy", PLW'(req_rdy), ((DEPTH - n) >= MI) ? 1 : 0);
    for (int i = 0; i < MO; i++) begin
      chk($sformatf("ack_vld%0d", i), PLW'(v_ack_vld[i]), (n > i) ? 1 : 0);
      if (n > i) chk($sformatf("ack_pld%0d", i), v_ack_pld[i], mq[i]);
    end
  endtask

  task automatic do_cycle(input logic cxl, input logic vld, input logic [1:0] en, input logic [1:0] rdy);
    logic [PLW-1:0] pl [MI];
    int n;
    int rdn;
    logic acc;
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < MI; i++) pl[i] = {$urandom, $urandom, $urandom, $urandom};
    cancel_en = cxl;
    req_vld   = vld;
    v_req_en  = en;
    v_ack_rdy = rdy;
    for (int i = 0; i < MI; i++) v_req_pld[i] = pl[i];
    n   = mq.size();
    acc = vld && ((DEPTH - n) >= MI);
    rdn = 0;
    for (int i = 0; i < MO; i++) begin
      if (rdn == i && i < n && rdy[i]) rdn++;
    end
    @(posedge clk);
    #1;
    if (cxl) begin
      mq.delete();
    end else begin
      repeat (rdn) void'(mq.pop_front());
      if (acc) begin
        for (int i = 0; i < MI; i++) if (en[i]) mq.push_back(pl[i]);
      end
    end
    cancel_en = 1'b0;
    req_vld   = 1'b0;
    v_req_en  = '0;
    v_ack_rdy = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 2'b00, 1,  1'b1};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 2'b00, 2,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 2'b10, 2,  1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 2'b11, 2,  1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 2'b11, 1,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b11, 0,  1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b11, 0,  1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b11, 2'b00, 0,  1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 2'b00, 1,  1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b11, 0,  1'b1};

    rst_n = 1'b0; cancel_en = 1'b0; req_vld = 1'b0; v_req_en = '0; v_ack_rdy = '0; v_req_pld = '0;
    repeat (2) @(negedge clk);
    chk("rst_occ", PLW'(occ_cnt), 0);
    chk("rst_rdy", PLW'(req_rdy), 1);
    chk("rst_vld", PLW'(v_ack_vld), 0);
    rst_n = 1'b1;

    // Table: small write/read/cancel patterns with explicit expected occupancy.
    for (int k = 0; k < 12; k++) begin
      do_cycle(vecs[k].cxl, vecs[k].vld, vecs[k].en, vecs[k].rdy);
      chk($sformatf("vec%0d_occ", k), PLW'(occ_cnt), PLW'(vecs[k].exp_occ));
      chk($sformatf("vec%0d_rdy", k), PLW'(req_rdy), PLW'(vecs[k].exp_rdy));
    end

    // Fill to full, credit stays closed until two slots free.
    repeat (16) do_cycle(1'b0, 1'b1, 2'b11, 2'b00);
    chk("full_occ", PLW'(occ_cnt), 32);
    chk("full_rdy", PLW'(req_rdy), 0);
    do_cycle(1'b0, 1'b1, 2'b01, 2'b00);
    chk("full_nowrite", PLW'(occ_cnt), 32);
    do_cycle(1'b0, 1'b0, 2'b00, 2'b01);
    chk("rd1_occ", PLW'(occ_cnt), 31);
    chk("rd1_rdy", PLW'(req_rdy), 0);
    do_cycle(1'b0, 1'b1, 2'b01, 2'b00);
    chk("partial_credit", PLW'(occ_cnt), 31);
    do_cycle(1'b0, 1'b0, 2'b00, 2'b01);
    chk("rd2_occ", PLW'(occ_cnt), 30);
    chk("rd2_rdy", PLW'(req_rdy), 1);
    repeat (15) do_cycle(1'b0, 1'b0, 2'b00, 2'b11);
    chk("drain_occ", PLW'(occ_cnt), 0);

    // Steady streaming across multiple wraps.
    do_cycle(1'b0, 1'b1, 2'b11, 2'b00);
    for (int c = 0; c < 100; c++) begin
      do_cycle(1'b0, 1'b1, 2'b11, 2'b11);
      chk("stream_occ", PLW'(occ_cnt), 2);
    end
    do_cycle(1'b1, 1'b1, 2'b11, 2'b11);
    chk("cancel_occ", PLW'(occ_cnt), 0);
    chk("cancel_vld", PLW'(v_ack_vld), 0);

    // Non-thermometer ready consumes nothing.
    do_cycle(1'b0, 1'b1, 2'b11, 2'b00);
    do_cycle(1'b0, 1'b0, 2'b00, 2'b10);
    chk("nonthermo_occ", PLW'(occ_cnt), 2);

    // Asynchronous reset mid-burst.
    repeat (3) do_cycle(1'b0, 1'b1, 2'b11, 2'b00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_occ", PLW'(occ_cnt), 0);
    chk("arst_rdy", PLW'(req_rdy), 1);
    chk("arst_vld", PLW'(v_ack_vld), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b0, 1'b1, 2'b10, 2'b00);
    @(negedge clk);
    check_outputs();
    chk("post_rst_lane0", PLW'(v_ack_vld), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toy_fetch_buffer_mw.md
# toy_fetch_buffer_mw

Multi-lane in-order fetch buffer. It sits between the fetch/predecode stage and decode, and succeeds the single-output fetch buffer. The block accepts up to MUX_IN instructions per cycle on sparse-enabled lanes and compacts them in lane order. It presents up to MUX_OUT oldest entries per cycle to decode, releases entries on a contiguous-prefix handshake, and clears on cancel.

## Interface
- DEPTH, 32: entry count; power of two, DEPTH >= 2*max(MUX_IN, MUX_OUT).
- MUX_IN, 2: write lanes per cycle, 1..8.
- MUX_OUT, 2: read lanes per cycle, 1..8.
- PLD_WIDTH, 128: bits per entry (pc, inst, bypass fields packed by the caller).

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cancel_en  input  1  flush; empties the buffer on the next edge.
- req_vld  input  1  write group valid.
- req_rdy  output  1  write group can be accepted; reset value 1.
- v_req_en  input  MUX_IN  per-lane write enable; any pattern, including holes.
- v_req_pld  input  MUX_IN x PLD_WIDTH  per-lane payload.
- v_ack_vld  output  MUX_OUT  lane i holds the i-th oldest entry; reset value 0.
- v_ack_rdy  input  MUX_OUT  consumer accept; must be a thermometer (lane 0 upward).
- v_ack_pld  output  MUX_OUT x PLD_WIDTH  payload of the i-th oldest entry.
- occ_cnt  output  $clog2(DEPTH)+1  current occupancy; reset value 0.

## Operation
- Storage and pointers:
  - Circular array of DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. The low bits index the array.
  - occ_cnt = wr_ptr - rd_ptr, held as a separate register that is updated consistently with the pointers.
- Write accept:
  - wren = req_vld & req_rdy.
  - req_rdy = (DEPTH - occ_cnt) >= MUX_IN, from the registered count only. Same-cycle reads do not raise it.
- Write compaction:
  - Lane i with v_req_en[i]=1 is written to wr_ptr + popcount(v_req_en[i-1:0]).
  - wr_ptr advances by popcount(v_req_en).
  - A group with req_vld=1 and v_req_en=0 is accepted and changes nothing.
- Read side:
  - v_ack_vld[i] = occ_cnt > i.
  - v_ack_pld[i] = entry at rd_ptr + i, modulo DEPTH.
  - rd_num = number of leading lanes with v_ack_vld & v_ack_rdy. Counting stops at the first lane where either is 0.
  - rd_ptr advances by rd_num.
  - A non-thermometer v_ack_rdy is a protocol error. Lanes above the first hole are not consumed.
- Count update:
  - occ_cnt_next = occ_cnt + (wren ? popcount(v_req_en) : 0) - rd_num.
  - Arithmetic is $clog2(DEPTH)+1 bits wide. occ_cnt never exceeds DEPTH and never underflows.
- Cancel:
  - Highest priority. On the next edge wr_ptr, rd_ptr and occ_cnt are set to 0.
  - Writes and reads presented in the cancel cycle are discarded; their handshakes are ignored.
  - Entry contents are not cleared.
- Payload of a lane with v_ack_vld=0 is don't-care.

## Timing
- Write-to-read latency: 1 cycle. An entry written at edge N appears on v_ack_* after edge N. There is no same-cycle bypass to an empty buffer.
- Read release: a consumed entry's slot is freed at the edge. req_rdy reflects the freed slot one cycle later.
- All outputs are combinational from registered state only. There is no input-to-output combinational path except the consumer-side v_ack_rdy -> nothing.
- Reset (asynchronous assert, synchronous deassert at the system level):
  - occ_cnt=0, v_ack_vld=0, req_rdy=1, pointers=0.
  - Reset mid-operation drops all contents immediately.
- Full: at occ_cnt > DEPTH - MUX_IN, req_rdy=0 even if fewer lanes are enabled (all-or-nothing credit).
- Empty: v_ack_vld=0. v_ack_rdy is ignored.
- Simultaneous write and read: both apply in the same edge. Net count per the formula above.
- Wrap-around: writes and reads straddling the DEPTH-1 -> 0 boundary split across the array ends without bubbles.

## Test plan
- Reset, then single writes with v_req_en=2'b10, payloads A then B, MUX_OUT=2:
  - After two writes, lane0=A, lane1=B, occ_cnt=2.
- Sparse compaction with MUX_IN=4, v_req_en=4'b1010, payloads P1/P3:
  - Next cycle lane0=P1, lane1=P3, occ_cnt=2, no hole entries.
- Fill to full with DEPTH=32, MUX_IN=2 and no reads:
  - After 16 full-lane writes occ_cnt=32 and req_rdy=0.
  - A single read with rdy=2'b01 gives occ_cnt=31; req_rdy stays 0 (31 > 30).
  - A second read gives occ_cnt=30 and req_rdy=1.
- Simultaneous traffic, then cancel:
  - Each cycle: write 2, read 2 with rdy=2'b11, for 100 cycles spanning multiple wraps. The output order matches a reference queue and occ_cnt stays constant.
  - Then cancel_en=1 together with req_vld=1: next cycle occ_cnt=0, v_ack_vld=0, and the written group is absent.
- Non-thermometer rdy=2'b10 with 2 entries: no entry is consumed and occ_cnt stays 2.
- Asynchronous reset asserted mid-burst:
  - Outputs go to their reset values without waiting for a clock edge.
  - The first write after release appears at lane0.
